// File: rtl/io_board_pkg.sv
// Shared widths, scan-state encoding and seven-segment table for the IO board responder.
package io_board_pkg;

    localparam int IO_IN_W    = 16;
    localparam int IO_OUT_W   = 12;
    localparam int NUM_DIGITS = 3;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-low {g,f,e,d,c,b,a}, entry 15 first so index n selects digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/io_board_responder_debounce.sv
// Switch input path: 2-flop synchroniser, sample tick and 3-deep per-bit debounce history.
module io_debounce
    import io_board_pkg::*;
#(
    parameter int DB_LIMIT = 50000,
    parameter int CNT_W    = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IO_IN_W-1:0] sw_raw,
    output logic [IO_IN_W-1:0] ioin,
    output logic               io_changed
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DB_LIMIT - 1);

    logic [IO_IN_W-1:0] sync1_r;
    logic [IO_IN_W-1:0] sync2_r;
    logic [IO_IN_W-1:0] h0_r;
    logic [IO_IN_W-1:0] h1_r;
    logic [IO_IN_W-1:0] h2_r;
    logic [IO_IN_W-1:0] ioin_r;
    logic [IO_IN_W-1:0] stable_s;
    logic [IO_IN_W-1:0] accept_s;
    logic [CNT_W-1:0]   tick_cnt_r;
    logic               tick_s;
    logic               tick_d_r;
    logic               io_changed_r;

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Synchroniser and free-running sample tick counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= '0;
            sync2_r    <= '0;
            tick_cnt_r <= '0;
            tick_d_r   <= 1'b0;
        end else begin
            sync1_r    <= sw_raw;
            sync2_r    <= sync1_r;
            tick_cnt_r <= tick_s ? '0 : tick_cnt_r + CNT_W'(1);
            tick_d_r   <= tick_s;
        end
    end

    // History shift register, advanced only on sample ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0_r <= '0;
            h1_r <= '0;
            h2_r <= '0;
        end else if (tick_s) begin
            h0_r <= sync2_r;
            h1_r <= h0_r;
            h2_r <= h1_r;
        end else begin
            h0_r <= h0_r;
            h1_r <= h1_r;
            h2_r <= h2_r;
        end
    end

    // A bit follows its history only once three consecutive samples agree.
    always_comb begin
        stable_s = ~(h0_r ^ h1_r) & ~(h1_r ^ h2_r);
        accept_s = (h0_r & stable_s) | (ioin_r & ~stable_s);
    end

    // Accept decision is taken the cycle after the tick that refreshed the history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ioin_r       <= '0;
            io_changed_r <= 1'b0;
        end else if (tick_d_r) begin
            ioin_r       <= accept_s;
            io_changed_r <= (accept_s != ioin_r);
        end else begin
            ioin_r       <= ioin_r;
            io_changed_r <= 1'b0;
        end
    end

    assign ioin       = ioin_r;
    assign io_changed = io_changed_r;

endmodule

// File: rtl/io_board_responder.sv
// Board-side IO responder: debounced switch input word, LED mirror and 3-digit multiplexed display.
module io_board_responder
    import io_board_pkg::*;
#(
    parameter int DB_LIMIT     = 50000,
    parameter int SCAN_LIMIT   = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IO_IN_W-1:0]  sw_raw,
    input  logic [IO_OUT_W-1:0] ioout,
    output logic [IO_IN_W-1:0]  ioin,
    output logic                io_changed,
    output logic [IO_OUT_W-1:0] led,
    output logic [2:0]          an,
    output logic [6:0]          seg
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_LIMIT - BLANK_CYCLES - 1);
    localparam logic [1:0]       DIGIT_LAST = 2'(NUM_DIGITS - 1);

    scan_state_t         state_r;
    scan_state_t         state_n;
    logic [1:0]          digit_r;
    logic [1:0]          digit_n;
    logic [CNT_W-1:0]    scan_cnt_r;
    logic [CNT_W-1:0]    scan_cnt_n;
    logic [3:0]          nib_r;
    logic [3:0]          nib_n;
    logic [3:0]          led_nib_s;
    logic [2:0]          an_r;
    logic [2:0]          an_n;
    logic [6:0]          seg_r;
    logic [6:0]          seg_n;
    logic [IO_OUT_W-1:0] led_r;

    io_debounce #(
        .DB_LIMIT (DB_LIMIT),
        .CNT_W    (CNT_W)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_raw     (sw_raw),
        .ioin       (ioin),
        .io_changed (io_changed)
    );

    // LED bank mirrors the processor output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= '0;
        end else begin
            led_r <= ioout;
        end
    end

    // Nibble of the LED copy belonging to the current digit.
    always_comb begin
        case (digit_r)
            2'd0:    led_nib_s = led_r[3:0];
            2'd1:    led_nib_s = led_r[7:4];
            2'd2:    led_nib_s = led_r[11:8];
            default: led_nib_s = led_r[3:0];
        endcase
    end

    // Scan FSM next state; the nibble is frozen on entry to SHOW so a slot never tears.
    always_comb begin
        state_n    = state_r;
        digit_n    = digit_r;
        scan_cnt_n = scan_cnt_r + CNT_W'(1);
        nib_n      = nib_r;
        an_n       = 3'b111;
        seg_n      = 7'b1111111;
        case (state_r)
            BLANK: begin
                if (scan_cnt_r == BLANK_LAST) begin
                    state_n    = SHOW;
                    scan_cnt_n = '0;
                    nib_n      = led_nib_s;
                end else begin
                    state_n    = BLANK;
                end
            end
            SHOW: begin
                if (scan_cnt_r == SHOW_LAST) begin
                    state_n    = BLANK;
                    scan_cnt_n = '0;
                    digit_n    = (digit_r == DIGIT_LAST) ? 2'd0 : digit_r + 2'd1;
                end else begin
                    state_n    = SHOW;
                end
            end
            default: begin
                state_n    = BLANK;
                scan_cnt_n = '0;
                digit_n    = 2'd0;
            end
        endcase
        if (state_n == SHOW) begin
            an_n  = ~(3'b001 << digit_n);
            seg_n = hex_to_seg(nib_n);
        end else begin
            an_n  = 3'b111;
            seg_n = 7'b1111111;
        end
    end

    // Scan state and registered display drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= BLANK;
            digit_r    <= 2'd0;
            scan_cnt_r <= '0;
            nib_r      <= 4'd0;
            an_r       <= 3'b111;
            seg_r      <= 7'b1111111;
        end else begin
            state_r    <= state_n;
            digit_r    <= digit_n;
            scan_cnt_r <= scan_cnt_n;
            nib_r      <= nib_n;
            an_r       <= an_n;
            seg_r      <= seg_n;
        end
    end

    assign led = led_r;
    assign an  = an_r;
    assign seg = seg_r;

endmodule

// File: doc/io_board_responder.md
Name: io_board_responder

Overview:
Board-side responder for the processor's memory-mapped IO port. It sits between the physical board and the processor top. It drives the processor's 16-bit ioin from debounced, synchronised switches. It also renders the processor's 12-bit ioout onto a 3-digit multiplexed seven-segment display and a 12-LED bank.

Parameters:
DB_LIMIT, 50000, clock cycles between debounce sample ticks (>=2)
SCAN_LIMIT, 100000, clock cycles each digit is selected, including blanking (> BLANK_CYCLES)
BLANK_CYCLES, 1000, cycles at the start of each digit slot with all anodes off (>=1)
CNT_W, 17, width of the tick and scan counters; must hold max(DB_LIMIT, SCAN_LIMIT)-1

Ports:
clk  in  1  system clock, same clock as the processor
rst_n  in  1  asynchronous active-low reset
sw_raw  in  16  raw board switches, asynchronous, may bounce
ioout  in  12  processor output word
ioin  out  16  debounced switch word to the processor
io_changed  out  1  one-cycle pulse when ioin updates
led  out  12  registered copy of ioout
an  out  3  digit anodes, active-low, one-hot-low when lit
seg  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All flops clear on rst_n low, independent of clk.
- Reset values:
  - ioin=0, io_changed=0, led=0.
  - an=3'b111, seg=7'b1111111.
  - Synchroniser, history and counters =0.
  - Scan FSM in BLANK with digit=0.
- Input path, synchroniser: 2-flop synchroniser per sw_raw bit gives sw_s.
- Input path, tick counter:
  - Counts 0..DB_LIMIT-1 and wraps.
  - tick=1 for one cycle when the count equals DB_LIMIT-1.
- Input path, per-bit history:
  - On tick, each bit shifts sw_s into a 3-deep history h[2:0] (h0 newest).
- Input path, accept rule:
  - On the cycle after a tick, bit i of ioin takes the new value when h0=h1=h2 and h0 differs from ioin[i]; otherwise ioin[i] holds.
  - io_changed=1 on exactly the cycle any ioin bit changes.
- Input path, latency: a level stable from before tick k is accepted at tick k+2, plus one cycle. A glitch shorter than 2 tick periods is never accepted. Bits are independent.
- Output path, LEDs: led <= ioout every cycle (1-cycle latency).
- Scan FSM states, BLANK and SHOW:
  - BLANK: an=111, seg=1111111. Counts BLANK_CYCLES cycles, then goes to SHOW.
  - On the BLANK->SHOW transition, nibble = led[4*digit+3 : 4*digit] is latched. The display stays tear-free while ioout changes mid-slot.
  - SHOW: an[digit]=0, other anodes 1. seg = hex_to_seg(latched nibble), for SCAN_LIMIT-BLANK_CYCLES cycles. Then the FSM goes to BLANK and digit increments.
  - digit wraps 2->0; value 3 is never reached.
- Segment encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Outputs an/seg are registered: no combinational path from ioout or sw_raw to any output.
- Reset mid-operation: all state returns to reset values immediately. After release, the first tick occurs DB_LIMIT cycles later, and scanning restarts at BLANK, digit 0.
- A tick and a scan transition in the same cycle are independent; neither delays the other.

Decomposition:
- Shared package io_board_pkg holds:
  - widths IO_IN_W=16, IO_OUT_W=12, NUM_DIGITS=3
  - the 16-entry seven-segment constant table
  - scan state encodings BLANK=1'b0, SHOW=1'b1
- One natural sub-module: io_debounce. It holds the synchroniser, the tick counter and the per-bit history/accept logic, and outputs ioin and io_changed.
- Scan FSM and segment lookup remain in the top.

Test Plan:
All tests use DB_LIMIT=4, SCAN_LIMIT=8, BLANK_CYCLES=2.
1. Reset: assert rst_n=0 mid-scan with sw_raw=FFFF -> ioin=0, an=111, seg=1111111, led=0 asynchronously. After release, ioin=FFFF after 3 ticks plus pipeline, with a single io_changed pulse.
2. Debounce reject: sw_raw[3] pulses high for 5 cycles (<2 tick periods) -> ioin stays 0000 and io_changed never fires. Held 20 cycles -> ioin=0008 with one io_changed pulse.
3. Independent bits: sw_raw 0000->8001 with bit0 bouncing 3 cycles -> ioin reaches 8001. Each bit changes at its own accept tick, and io_changed pulses once per ioin change.
4. Scan sequence: ioout=12'h3A7 -> repeating pattern of 2 blank cycles, an=110 seg=1111000 (7) for 6 cycles, blank, an=101 seg=0001000 (A), blank, an=011 seg=0110000 (3), then wraps to digit 0.
5. Tear-free: ioout changes 12'h3A7->12'h3A0 during digit-0 SHOW -> seg holds 1111000 until the slot ends. The next digit-0 slot shows 1000000. led updates 1 cycle after the change.
6. Full encode: sweep ioout[3:0] 0..F -> each digit-0 slot matches the table, including b, d and F.
